// File: rtl/data_bus_pkg.sv
// Shared definitions for the CPU data-space controller: address map,
// region decode values, error bit positions and the init FSM state type.
package data_bus_pkg;

    // Register block addresses
    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_BANK    = 8'h01;
    localparam logic [7:0] ADDR_ERR     = 8'h02;
    localparam logic [7:0] ADDR_ERRADDR = 8'h03;

    // RAM windows
    localparam logic [7:0] COMMON_LO = 8'h04;
    localparam logic [7:0] COMMON_HI = 8'h0F;
    localparam logic [7:0] WIN_LO    = 8'h10;
    localparam logic [7:0] WIN_HI    = 8'h7F;

    localparam int COMMON_SIZE = 12;
    localparam int WIN_SIZE    = 112;

    // ERR register bit positions
    localparam int ERR_BIT_RD     = 0;  // unmapped read
    localparam int ERR_BIT_WR     = 1;  // unmapped write
    localparam int ERR_BIT_STATUS = 2;  // write to read-only STATUS

    // Which part of the map an address falls into
    typedef enum logic [2:0] {
        REG,
        COMMON,
        WIN,
        SLOT,
        UNMAPPED
    } region_t;

    // RAM clear sequencer states
    typedef enum logic {
        INIT,
        RUN
    } init_state_t;

    // Physical RAM depth: common area followed by every bank window
    function automatic int ram_depth(input int banks);
        return COMMON_SIZE + banks * WIN_SIZE;
    endfunction

endpackage

// File: rtl/bus_ram_init.sv
// Data RAM with asynchronous read and a post-reset clear sequencer.
// The sequencer owns the write port while clearing; afterwards the CPU
// write path is routed through. The array itself has no reset so it can
// map onto distributed RAM.
module bus_ram_init #(
    parameter int DEPTH = 460,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_we,
    input  logic [IDX_W-1:0] cpu_idx,
    input  logic [7:0]       cpu_wdata,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic             init_busy
);
    import data_bus_pkg::*;

    logic [7:0]       mem [DEPTH];

    init_state_t      state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;

    logic             ram_we;
    logic [IDX_W-1:0] ram_widx;
    logic [7:0]       ram_wdata;

    // State and clear-counter registers; reset always restarts the clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state and write-port mux between the clear path and the CPU
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ram_we     = 1'b0;
        ram_widx   = cpu_idx;
        ram_wdata  = cpu_wdata;
        case (state_reg)
            INIT: begin
                ram_we    = 1'b1;
                ram_widx  = cnt_reg;
                ram_wdata = 8'h00;
                if (cnt_reg == IDX_W'(DEPTH - 1)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                ram_we = cpu_we;
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // Single write port into the array
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_widx] <= ram_wdata;
        end
    end

    // Asynchronous read; out-of-range indices read as zero
    assign rd_data   = (32'(rd_idx) < DEPTH) ? mem[rd_idx] : 8'h00;
    assign init_busy = (state_reg == INIT);

endmodule

// File: rtl/data_bus_ctrl.sv
// CPU data-space controller: register block, banked RAM with a common
// area, one-hot peripheral slot decode with muxed read data, and sticky
// bus-error capture. Reads are combinational; writes land on clk.
module data_bus_ctrl #(
    parameter int         BANKS     = 4,
    parameter int         N_PERI    = 4,
    parameter logic [7:0] SLOT_BASE = 8'h80,
    parameter int         SLOT_SPAN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            cpu_status,
    input  logic [7:0]            addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [N_PERI-1:0]     peri_sel,
    input  logic [8*N_PERI-1:0]   peri_rdata,
    output logic                  init_busy,
    output logic                  bus_err
);
    import data_bus_pkg::*;

    localparam int DEPTH  = ram_depth(BANKS);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic [7:0]        status_reg;
    logic [BANK_W-1:0] bank_reg;
    logic [2:0]        err_reg, err_next;
    logic [7:0]        erraddr_reg;

    logic              run;
    region_t           region;
    logic [7:0]        slot_off;
    logic              slot_zone;
    logic [N_PERI-1:0] slot_hit;
    logic [7:0]        peri_masked [N_PERI];
    logic [7:0]        peri_rd;

    logic [IDX_W-1:0]  ram_idx;
    logic [7:0]        ram_rdata;
    logic              ram_cpu_we;

    logic [2:0]        err_set;
    logic [2:0]        err_clr;
    logic [7:0]        bank_rd;

    assign run       = ~init_busy;
    assign slot_off  = addr - SLOT_BASE;
    assign slot_zone = addr[7] && (addr >= SLOT_BASE);

    // Per-slot range compare and read-data masking; widened to 32 bits so
    // slot bounds past 0xFF never wrap
    generate
        for (genvar gi = 0; gi < N_PERI; gi++) begin : g_slot
            assign slot_hit[gi] = slot_zone
                && ({24'd0, slot_off} >= 32'(gi * SLOT_SPAN))
                && ({24'd0, slot_off} <  32'((gi + 1) * SLOT_SPAN));
            assign peri_masked[gi] = slot_hit[gi] ? peri_rdata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    // OR-combine the masked slot data; at most one slot is ever hit
    always_comb begin
        peri_rd = 8'h00;
        for (int i = 0; i < N_PERI; i++) begin
            peri_rd = peri_rd | peri_masked[i];
        end
    end

    // Region decode of the current address
    always_comb begin
        if (addr <= ADDR_ERRADDR) begin
            region = REG;
        end else if (addr <= COMMON_HI) begin
            region = COMMON;
        end else if (addr <= WIN_HI) begin
            region = WIN;
        end else if (|slot_hit) begin
            region = SLOT;
        end else begin
            region = UNMAPPED;
        end
    end

    // Physical RAM index: common area first, then BANK-selected window
    always_comb begin
        ram_idx = '0;
        if (region == COMMON) begin
            ram_idx = IDX_W'(addr - COMMON_LO);
        end else if (region == WIN) begin
            ram_idx = IDX_W'(COMMON_SIZE)
                    + IDX_W'(bank_reg) * IDX_W'(WIN_SIZE)
                    + IDX_W'(addr - WIN_LO);
        end
    end

    assign ram_cpu_we = wr_en && ((region == COMMON) || (region == WIN));

    bus_ram_init #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (ram_cpu_we),
        .cpu_idx   (ram_idx),
        .cpu_wdata (wdata),
        .rd_idx    (ram_idx),
        .rd_data   (ram_rdata),
        .init_busy (init_busy)
    );

    // New error bits and write-1-to-clear mask; nothing is flagged while clearing
    always_comb begin
        err_set = 3'b000;
        err_clr = 3'b000;
        if (run) begin
            err_set[ERR_BIT_RD]     = rd_en && (region == UNMAPPED);
            err_set[ERR_BIT_WR]     = wr_en && (region == UNMAPPED);
            err_set[ERR_BIT_STATUS] = wr_en && (addr == ADDR_STATUS);
            if (wr_en && (addr == ADDR_ERR)) begin
                err_clr = wdata[2:0];
            end
        end
        // A new error on a bit beats a clear of that bit
        err_next = (err_reg & ~err_clr) | err_set;
    end

    // Register block state
    always_ff @(posedge clk) begin
        if (reset) begin
            status_reg  <= 8'h00;
            bank_reg    <= '0;
            err_reg     <= 3'b000;
            erraddr_reg <= 8'h00;
        end else begin
            status_reg <= cpu_status;
            err_reg    <= err_next;
            if (|err_set) begin
                erraddr_reg <= addr;
            end
            if (run && wr_en && (addr == ADDR_BANK) && (BANKS > 1)) begin
                bank_reg <= wdata[BANK_W-1:0];
            end
        end
    end

    assign bank_rd = (BANKS > 1) ? 8'(bank_reg) : 8'h00;

    // Combinational read mux; forced to zero while the RAM is clearing
    always_comb begin
        rdata = 8'h00;
        if (run) begin
            case (region)
                REG: begin
                    case (addr[1:0])
                        2'd0:    rdata = status_reg;
                        2'd1:    rdata = bank_rd;
                        2'd2:    rdata = {5'b00000, err_reg};
                        default: rdata = erraddr_reg;
                    endcase
                end
                COMMON, WIN: rdata = ram_rdata;
                SLOT:        rdata = peri_rd;
                default:     rdata = 8'h00;
            endcase
        end
    end

    assign peri_sel = run ? slot_hit : '0;
    assign bus_err  = (|err_reg) & ~reset;

endmodule
